// File: rtl/cpu_trace_monitor_if.sv
// Trace monitor bus: master is the CPU/host side, slave is the monitor.
interface cpu_trace_monitor_if #(
    parameter int XLEN  = 32,
    parameter int DEPTH = 16,
    parameter int CNT_W = 32
);
    logic                       start_i;
    logic                       wb_en_i;
    logic [4:0]                 wb_rd_i;
    logic [XLEN-1:0]            wb_data_i;
    logic [XLEN-1:0]            wb_pc_i;
    logic [31:0]                id_instr_i;
    logic                       stall_i;
    logic                       rd_en_i;
    logic                       trace_valid_o;
    logic [4:0]                 trace_rd_o;
    logic [XLEN-1:0]            trace_data_o;
    logic [XLEN-1:0]            trace_pc_o;
    logic [$clog2(DEPTH):0]     count_o;
    logic                       overflow_o;
    logic                       halt_o;
    logic [1:0]                 state_o;
    logic [CNT_W-1:0]           cycle_cnt_o;
    logic [CNT_W-1:0]           retire_cnt_o;
    logic [CNT_W-1:0]           drop_cnt_o;

    modport master (
        output start_i, wb_en_i, wb_rd_i, wb_data_i, wb_pc_i, id_instr_i, stall_i, rd_en_i,
        input  trace_valid_o, trace_rd_o, trace_data_o, trace_pc_o, count_o, overflow_o,
               halt_o, state_o, cycle_cnt_o, retire_cnt_o, drop_cnt_o
    );

    modport slave (
        input  start_i, wb_en_i, wb_rd_i, wb_data_i, wb_pc_i, id_instr_i, stall_i, rd_en_i,
        output trace_valid_o, trace_rd_o, trace_data_o, trace_pc_o, count_o, overflow_o,
               halt_o, state_o, cycle_cnt_o, retire_cnt_o, drop_cnt_o
    );
endinterface

// File: rtl/cpu_trace_monitor.sv
// Commit-trace monitor: buffers register write-backs in a show-ahead FIFO,
// keeps cycle/retire/drop counters and detects end of program.
//
//   state | meaning
//   IDLE  | waiting for start, nothing captured
//   RUN   | capturing, watching ID for a run of zero instructions
//   DRAIN | capturing in-flight write-backs for DRAIN_CYC cycles
//   DONE  | capture frozen, FIFO still poppable, halt once empty
module cpu_trace_monitor #(
    parameter int XLEN      = 32,
    parameter int DEPTH     = 16,
    parameter int CNT_W     = 32,
    parameter int HALT_RUN  = 1,
    parameter int DRAIN_CYC = 3
) (
    input  logic              clk_i,
    input  logic              rst_i,
    cpu_trace_monitor_if.slave bus
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam int ZW = $clog2(HALT_RUN + 1);
    localparam int DW = (DRAIN_CYC < 2) ? 1 : $clog2(DRAIN_CYC);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_DRAIN = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t           state_q, state_d;
    logic [ZW-1:0]    zrun_q, zrun_d;
    logic [DW-1:0]    dcnt_q, dcnt_d;
    logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
    logic [CW-1:0]    count_q;
    logic [CNT_W-1:0] cycle_q, retire_q, drop_q;
    logic             overflow_q, halt_q;

    logic [4:0]       mem_rd   [DEPTH];
    logic [XLEN-1:0]  mem_data [DEPTH];
    logic [XLEN-1:0]  mem_pc   [DEPTH];

    logic capture, empty, full, pop, push_req, push, drop;

    assign capture  = (state_q == S_RUN) || (state_q == S_DRAIN);
    assign empty    = (count_q == '0);
    assign full     = (count_q == CW'(DEPTH));
    assign pop      = bus.rd_en_i && !empty;
    assign push_req = capture && bus.wb_en_i && (bus.wb_rd_i != '0);
    // A pop frees the slot on the same edge, so a push into a full FIFO survives.
    assign push     = push_req && (!full || pop);
    assign drop     = push_req && full && !pop;

    always_comb begin
        state_d = state_q;
        zrun_d  = zrun_q;
        dcnt_d  = dcnt_q;
        unique case (state_q)
            S_IDLE: begin
                if (bus.start_i) begin
                    state_d = S_RUN;
                    zrun_d  = '0;
                end
            end
            S_RUN: begin
                if (!bus.stall_i) begin
                    if (bus.id_instr_i != '0) begin
                        zrun_d = '0;
                    end else if (zrun_q == ZW'(HALT_RUN - 1)) begin
                        zrun_d  = '0;
                        dcnt_d  = DW'(DRAIN_CYC - 1);
                        state_d = (DRAIN_CYC == 0) ? S_DONE : S_DRAIN;
                    end else begin
                        zrun_d = zrun_q + 1'b1;
                    end
                end
            end
            S_DRAIN: begin
                if (dcnt_q == '0) state_d = S_DONE;
                else              dcnt_d  = dcnt_q - 1'b1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q    <= S_IDLE;
            zrun_q     <= '0;
            dcnt_q     <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            cycle_q    <= '0;
            retire_q   <= '0;
            drop_q     <= '0;
            overflow_q <= 1'b0;
            halt_q     <= 1'b0;
        end else begin
            state_q <= state_d;
            zrun_q  <= zrun_d;
            dcnt_q  <= dcnt_d;
            if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
            if (push && !pop)      count_q <= count_q + 1'b1;
            else if (pop && !push) count_q <= count_q - 1'b1;
            if (capture && cycle_q != '1)                 cycle_q  <= cycle_q + 1'b1;
            if (capture && bus.wb_en_i && retire_q != '1) retire_q <= retire_q + 1'b1;
            if (drop && drop_q != '1)                     drop_q   <= drop_q + 1'b1;
            if (drop) overflow_q <= 1'b1;
            if (state_q == S_DONE && empty) halt_q <= 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (push) begin
            mem_rd[wr_ptr_q]   <= bus.wb_rd_i;
            mem_data[wr_ptr_q] <= bus.wb_data_i;
            mem_pc[wr_ptr_q]   <= bus.wb_pc_i;
        end
    end

    assign bus.trace_valid_o = !empty;
    assign bus.trace_rd_o    = empty ? '0 : mem_rd[rd_ptr_q];
    assign bus.trace_data_o  = empty ? '0 : mem_data[rd_ptr_q];
    assign bus.trace_pc_o    = empty ? '0 : mem_pc[rd_ptr_q];
    assign bus.count_o       = count_q;
    assign bus.overflow_o    = overflow_q;
    assign bus.halt_o        = halt_q;
    assign bus.state_o       = state_q;
    assign bus.cycle_cnt_o   = cycle_q;
    assign bus.retire_cnt_o  = retire_q;
    assign bus.drop_cnt_o    = drop_q;
endmodule

// File: tb/tb_cpu_trace_monitor.sv
// Directed bench for cpu_trace_monitor: FIFO order, x0 filtering, overflow,
// halt/drain sequencing, stall hold and asynchronous reset.
module tb_cpu_trace_monitor;
    localparam int XLEN = 32, DEPTH = 16, CNT_W = 32, HALT_RUN = 2, DRAIN_CYC = 3;
    localparam logic [31:0] NOP = 32'h0000_0013;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   errors = 0;
    int   checks = 0;
    int   cyc_exp = 0;
    bit   cap = 1'b0;

    always #5 clk = ~clk;

    cpu_trace_monitor_if #(.XLEN(XLEN), .DEPTH(DEPTH), .CNT_W(CNT_W)) bus ();

    cpu_trace_monitor #(
        .XLEN(XLEN), .DEPTH(DEPTH), .CNT_W(CNT_W),
        .HALT_RUN(HALT_RUN), .DRAIN_CYC(DRAIN_CYC)
    ) dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        if (cap) cyc_exp++;
        #1;
    endtask

    task automatic wb(input int rd, input logic [31:0] data, input logic [31:0] pc, input logic pop);
        bus.wb_en_i   = 1'b1;
        bus.wb_rd_i   = 5'(rd);
        bus.wb_data_i = data;
        bus.wb_pc_i   = pc;
        bus.rd_en_i   = pop;
        tick();
        bus.wb_en_i   = 1'b0;
        bus.rd_en_i   = 1'b0;
    endtask

    task automatic pop_one();
        bus.rd_en_i = 1'b1;
        tick();
        bus.rd_en_i = 1'b0;
    endtask

    task automatic check_reset(input string pfx);
        check({pfx, "_state"},    64'(bus.state_o),       64'd0);
        check({pfx, "_valid"},    64'(bus.trace_valid_o), 64'd0);
        check({pfx, "_count"},    64'(bus.count_o),       64'd0);
        check({pfx, "_head_rd"},  64'(bus.trace_rd_o),    64'd0);
        check({pfx, "_head_dat"}, 64'(bus.trace_data_o),  64'd0);
        check({pfx, "_head_pc"},  64'(bus.trace_pc_o),    64'd0);
        check({pfx, "_ovf"},      64'(bus.overflow_o),    64'd0);
        check({pfx, "_halt"},     64'(bus.halt_o),        64'd0);
        check({pfx, "_cycle"},    64'(bus.cycle_cnt_o),   64'd0);
        check({pfx, "_retire"},   64'(bus.retire_cnt_o),  64'd0);
        check({pfx, "_drop"},     64'(bus.drop_cnt_o),    64'd0);
    endtask

    initial begin
        bus.start_i    = 1'b0;
        bus.wb_en_i    = 1'b0;
        bus.wb_rd_i    = '0;
        bus.wb_data_i  = '0;
        bus.wb_pc_i    = '0;
        bus.id_instr_i = NOP;
        bus.stall_i    = 1'b0;
        bus.rd_en_i    = 1'b0;

        #2 rst = 1'b1;
        #20;
        check_reset("rst");
        rst = 1'b0;
        tick();

        // IDLE ignores write-backs
        wb(3, 32'hDEAD, 32'h100, 1'b0);
        check("idle_count",  64'(bus.count_o),      64'd0);
        check("idle_retire", 64'(bus.retire_cnt_o), 64'd0);

        bus.start_i = 1'b1;
        tick();
        bus.start_i = 1'b0;
        cap = 1'b1;
        check("start_state", 64'(bus.state_o), 64'd1);

        for (int i = 1; i <= 5; i++) wb(i, 32'hA0 + i, 32'h10008 + 4 * (i - 1), 1'b0);
        check("five_count",  64'(bus.count_o),       64'd5);
        check("five_valid",  64'(bus.trace_valid_o), 64'd1);
        check("five_rd",     64'(bus.trace_rd_o),    64'd1);
        check("five_pc",     64'(bus.trace_pc_o),    64'h10008);
        check("five_data",   64'(bus.trace_data_o),  64'hA1);
        check("five_retire", 64'(bus.retire_cnt_o),  64'd5);

        for (int i = 1; i <= 5; i++) begin
            check("pop_rd", 64'(bus.trace_rd_o), 64'(i));
            check("pop_pc", 64'(bus.trace_pc_o), 64'(32'h10008 + 4 * (i - 1)));
            pop_one();
        end
        check("popped_valid", 64'(bus.trace_valid_o), 64'd0);
        check("popped_count", 64'(bus.count_o),       64'd0);

        wb(0, 32'h1234, 32'h1001C, 1'b0);
        check("x0_retire", 64'(bus.retire_cnt_o), 64'd6);
        check("x0_count",  64'(bus.count_o),      64'd0);

        for (int i = 0; i < 20; i++) wb(i % 31 + 1, 32'h100 + i, 32'h20000 + 4 * i, 1'b0);
        check("full_count",  64'(bus.count_o),      64'd16);
        check("full_drop",   64'(bus.drop_cnt_o),   64'd4);
        check("full_ovf",    64'(bus.overflow_o),   64'd1);
        check("full_retire", 64'(bus.retire_cnt_o), 64'd26);
        check("full_head",   64'(bus.trace_rd_o),   64'd1);

        for (int i = 20; i < 24; i++) wb(i + 1, 32'h100 + i, 32'h20000 + 4 * i, 1'b1);
        check("pp_drop",   64'(bus.drop_cnt_o),   64'd4);
        check("pp_count",  64'(bus.count_o),      64'd16);
        check("pp_head",   64'(bus.trace_rd_o),   64'd5);
        check("pp_retire", 64'(bus.retire_cnt_o), 64'd30);

        for (int i = 0; i < 12; i++) pop_one();
        check("wrap_head_rd",  64'(bus.trace_rd_o),   64'd21);
        check("wrap_head_dat", 64'(bus.trace_data_o), 64'h114);
        check("wrap_count",    64'(bus.count_o),      64'd4);
        for (int i = 0; i < 4; i++) pop_one();
        check("empty_valid", 64'(bus.trace_valid_o), 64'd0);
        check("run_cycle",   64'(bus.cycle_cnt_o),   64'(cyc_exp));

        // zero instruction held by a stall never counts toward the halt run
        bus.id_instr_i = 32'h0;
        bus.stall_i    = 1'b1;
        for (int i = 0; i < 4; i++) tick();
        bus.stall_i = 1'b0;
        check("stall_state", 64'(bus.state_o),     64'd1);
        check("stall_cycle", 64'(bus.cycle_cnt_o), 64'(cyc_exp));

        tick();
        bus.id_instr_i = NOP;
        tick();
        check("run_broken", 64'(bus.state_o), 64'd1);
        bus.id_instr_i = 32'h0;
        tick();
        check("zero1_state", 64'(bus.state_o), 64'd1);
        tick();
        check("zero2_state", 64'(bus.state_o), 64'd2);
        bus.id_instr_i = NOP;

        wb(7, 32'h77, 32'h30000, 1'b0);
        check("drain1_state", 64'(bus.state_o), 64'd2);
        wb(8, 32'h88, 32'h30004, 1'b0);
        check("drain2_state", 64'(bus.state_o), 64'd2);
        wb(9, 32'h99, 32'h30008, 1'b0);
        check("drain3_state", 64'(bus.state_o), 64'd3);
        cap = 1'b0;

        bus.start_i = 1'b1;
        wb(10, 32'hAA, 32'h3000C, 1'b0);
        bus.start_i = 1'b0;
        check("done_state",  64'(bus.state_o),      64'd3);
        check("done_count",  64'(bus.count_o),      64'd3);
        check("done_retire", 64'(bus.retire_cnt_o), 64'd33);
        check("done_cycle",  64'(bus.cycle_cnt_o),  64'(cyc_exp));
        check("done_halt",   64'(bus.halt_o),       64'd0);

        for (int i = 0; i < 3; i++) begin
            check("done_pop_rd", 64'(bus.trace_rd_o), 64'(7 + i));
            pop_one();
        end
        check("lastpop_count", 64'(bus.count_o), 64'd0);
        check("lastpop_halt",  64'(bus.halt_o),  64'd0);
        tick();
        check("halt_set",  64'(bus.halt_o),     64'd1);
        check("halt_drop", 64'(bus.drop_cnt_o), 64'd4);

        rst = 1'b1;
        #2 rst = 1'b0;
        tick();
        bus.start_i = 1'b1;
        tick();
        bus.start_i = 1'b0;
        for (int i = 11; i <= 13; i++) wb(i, 32'h0 + i, 32'h40000 + 4 * i, 1'b0);
        bus.id_instr_i = 32'h0;
        tick();
        tick();
        bus.id_instr_i = NOP;
        check("pre_rst_state", 64'(bus.state_o), 64'd2);
        check("pre_rst_count", 64'(bus.count_o), 64'd3);
        #2 rst = 1'b1;
        #1;
        check_reset("async_rst");
        rst = 1'b0;
        tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/cpu_trace_monitor.md
# cpu_trace_monitor

Synthesizable, parametrised commit-trace monitor for the pipelined RISC-V CPU. It snoops the write-back port and the ID-stage instruction, buffers register-write events (rd, data, PC) in a show-ahead FIFO for a host or bench to drain, and keeps cycle, retire and drop counters. It also detects the end-of-program condition (a run of all-zero instructions in ID), drains in-flight write-backs and raises a sticky halt flag. It sits beside `CPU` at top level and replaces per-cycle register dumping with event-based tracing.

## Interface
- `XLEN`, 32, data and PC width
- `DEPTH`, 16, FIFO entries; power of two, ≥2
- `CNT_W`, 32, width of every counter
- `HALT_RUN`, 1, consecutive non-stalled zero instructions in ID that signal end of program (≥1)
- `DRAIN_CYC`, 3, cycles of continued capture after halt detection (in-flight ID→WB depth)

- `clk_i` in 1 — single clock, rising edge
- `rst_i` in 1 — asynchronous, active-high reset
- `start_i` in 1 — level; IDLE→RUN when high
- `wb_en_i` in 1 — register write-back valid this cycle
- `wb_rd_i` in 5 — destination register
- `wb_data_i` in XLEN — write-back data
- `wb_pc_i` in XLEN — PC of the retiring instruction
- `id_instr_i` in 32 — instruction currently in ID
- `stall_i` in 1 — ID stage stalled; instruction not advancing
- `rd_en_i` in 1 — pop FIFO head; ignored when `trace_valid_o`=0
- `trace_valid_o` out 1 — FIFO non-empty
- `trace_rd_o` out 5, `trace_data_o` out XLEN, `trace_pc_o` out XLEN — FIFO head entry
- `count_o` out $clog2(DEPTH)+1 — current occupancy
- `overflow_o` out 1 — sticky; at least one event dropped
- `halt_o` out 1 — sticky; program finished and FIFO empty
- `state_o` out 2 — IDLE=0, RUN=1, DRAIN=2, DONE=3
- `cycle_cnt_o`, `retire_cnt_o`, `drop_cnt_o` out CNT_W each

## Operation
- Reset: state IDLE, FIFO empty, all counters 0, `overflow_o`=0, `halt_o`=0, `trace_valid_o`=0, `count_o`=0; head outputs 0.
- IDLE: nothing captured or counted. `start_i`=1 → RUN next edge.
- RUN/DRAIN (capture states), per cycle:
  - `cycle_cnt_o` +1.
  - `wb_en_i`=1: `retire_cnt_o` +1. If `wb_rd_i`≠0, push {rd, data, pc}; writes to x0 are counted but never pushed.
  - Push while full and no pop in the same cycle: entry dropped, `drop_cnt_o` +1, `overflow_o`←1.
  - Push while full with pop in the same cycle: both take effect; no drop.
- Halt detection (RUN only): zero-run counter increments when `id_instr_i`==0 and `stall_i`=0; resets to 0 on any non-zero instruction; holds when `stall_i`=1. Reaching `HALT_RUN` → DRAIN next edge; DRAIN-cycle counter cleared.
- DRAIN: capture continues for exactly `DRAIN_CYC` cycles, then → DONE.
- DONE: no capture; counters frozen; FIFO still poppable. `halt_o`←1 on the first cycle in DONE with the FIFO empty; sticky until reset.
- `start_i` is ignored outside IDLE. Only `rst_i` leaves DONE.
- All counters saturate at 2^CNT_W−1 and do not wrap.
- FIFO pointers wrap modulo `DEPTH`. Occupancy is tracked with an extra count bit so full and empty are distinguished.
- Reset asserted mid-operation clears all state immediately; FIFO contents are discarded.

## Timing
- Push at edge N: entry visible on head outputs, and `trace_valid_o`=1, after edge N (registered, 1-cycle latency) if the FIFO was empty.
- Show-ahead FIFO: head outputs are valid whenever `trace_valid_o`=1. `rd_en_i` at edge N presents the next entry after N.
- `count_o`, counters and flags update on the same edge as the event that changes them.
- Halt latency: the last zero instruction of the run is sampled at edge N → `state_o`=DRAIN after N. Last capture edge is N+`DRAIN_CYC`. DONE after N+`DRAIN_CYC`. `halt_o` after the first edge where DONE holds with an empty FIFO.
- No combinational path from any input to any output except `rd_en_i` → nothing (pop takes effect at the edge).

## Test plan
- Reset then `start_i`: 5 write-backs to x1..x5 with PC 0x10008..0x10018 and `rd_en_i`=0 → `count_o`=5, head rd=1, pc=0x10008; 5 pops return entries in order; `trace_valid_o`=0 afterwards.
- Write-back to x0 with data 0x1234 → `retire_cnt_o` +1, `count_o` unchanged.
- DEPTH=16: 20 back-to-back pushes without pops → `count_o`=16, `drop_cnt_o`=4, `overflow_o`=1. Repeat with `rd_en_i` held high while full → no drops.
- HALT_RUN=2, DRAIN_CYC=3: one zero instruction, then non-zero, then two zeros → DRAIN only after the second consecutive zero. Write-backs in the 3 DRAIN cycles are captured; a 4th is not. `halt_o`=1 one cycle after the last pop.
- Zero instruction with `stall_i`=1 for 4 cycles → no halt. `cycle_cnt_o` still increments.
- Assert `rst_i` mid-DRAIN with 3 entries queued → all outputs return to reset values asynchronously.
